gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Synthesizable, parametrised exhaustive-sweep checker for N-input logic gates on the Basys3 board. On `start` it drives every input combination of a WIDTH-input gate under test, holding each combination for DWELL cycles. On the last cycle of each hold it compares the DUT output with a golden model for the selected gate mode, then reports error count, first failing vector and pass/fail. It sits between the board switches/buttons and a gate DUT, and replaces hand-written per-gate stimulus sequences with an in-fabric self-checking sweep.

## Interface
- `WIDTH`, default 2: number of DUT inputs; range 1–8.
- `DWELL`, default 50: cycles each vector is held; minimum 1.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a sweep; sampled only in IDLE or DONE.
- `mode`  in  3: gate select, latched on accepted `start`. 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6–7 reserved.
- `dut_out`  in  1: DUT output, combinational from `stim`.
- `stim`  out  WIDTH: vector driven to the DUT.
- `busy`  out  1: sweep in progress.
- `done`  out  1: sweep complete; held until the next accepted `start` or `rst`.
- `pass`  out  1: `done && err_count == 0`.
- `err_count`  out  WIDTH+1: number of mismatching vectors.
- `first_fail`  out  WIDTH: index of the first mismatching vector; meaningful only when `err_count != 0`.

## Operation
- States:
  - IDLE: wait for `start`.
  - DRIVE: hold the current vector and count dwell cycles.
  - DONE: report results and wait for a new `start`.
- IDLE → DRIVE on `start`:
  - latch `mode`;
  - clear `stim`, dwell counter, `err_count` and `first_fail`.
- DRIVE, dwell counter runs 0..DWELL-1. At count DWELL-1:
  - sample `dut_out` and compare with the expected value;
  - on mismatch, increment `err_count`; if it was 0, load `first_fail` with `stim`;
  - if `stim` is the all-ones vector, go to DONE; otherwise increment `stim` and reset the dwell counter.
- DONE → DRIVE on `start`, with a full clear as above. `start` in DRIVE is ignored.
- Expected value is the reduction of `stim` per mode: &, |, ^, ~&, ~|, ~^. Reserved modes expect constant 0.
- `err_count` is WIDTH+1 bits and cannot overflow: the maximum is 2^WIDTH.
- `rst` at any point returns to IDLE on the next edge and zeroes all outputs.

## Timing
- Reset value of every output is 0.
- `stim` changes only on clock edges, so `dut_out` has a full cycle to settle.
- `busy` rises the cycle after `start` is accepted and stays high for exactly 2^WIDTH × DWELL cycles.
- `done` and the final `err_count`/`first_fail` appear in the cycle `busy` falls.
- DWELL=1: every cycle is a sample cycle, and `stim` advances each cycle.
- Simultaneous `start` and `rst`: `rst` wins.

## Configuration
- `GSC_LOOPBACK_EN` defined:
  - `dut_out` is ignored;
  - an internal `gate_ref` instance, driven by `stim` and the latched mode, supplies the DUT output;
  - every sweep must report `pass` (board self-test).
- Undefined: `dut_out` is used; `gate_ref` is instantiated only for the expected value.

## Structure
- Shared package `gsc_pkg`:
  - mode encodings (`GSC_AND`…`GSC_XNOR`);
  - FSM state encoding (IDLE/DRIVE/DONE);
  - WIDTH and DWELL bound constants.
- Sub-module `gate_ref`: combinational, parametrised on WIDTH, mode-selected reduction. It is the golden model, and the loopback DUT when `GSC_LOOPBACK_EN` is defined.

## Test plan
- WIDTH=2, DWELL=4, mode AND, correct external AND DUT, `start` → `busy` for 16 cycles, `stim` 0,1,2,3, then `done`=1, `err_count`=0, `pass`=1.
- WIDTH=2, DWELL=4, mode AND, DUT stuck-at-0 → `err_count`=1, `first_fail`=3, `pass`=0.
- WIDTH=3, DWELL=2, mode XOR, DUT is a 3-input OR → `err_count`=3 (vectors 3, 5, 6), `first_fail`=3.
- WIDTH=2, DWELL=4, `rst` asserted in cycle 6 of the sweep → next cycle IDLE with all outputs 0; a new `start` runs a full 16-cycle sweep.
- `start` pulsed mid-sweep, then again in DONE with mode changed OR→NOR → first pulse ignored; second pulse clears counters, latches NOR and sweeps again.
- `GSC_LOOPBACK_EN` defined, WIDTH=4, DWELL=1, each of modes 0–5 → `pass`=1 after 16 busy cycles for each mode.

Source files
------------

// File: rtl/gsc_pkg.sv
// Shared encodings for the gate sweep checker: gate modes, FSM states and
// the legal parameter ranges.
package gsc_pkg;

  typedef logic [2:0] gsc_mode_t;

  localparam gsc_mode_t GSC_AND  = 3'd0;
  localparam gsc_mode_t GSC_OR   = 3'd1;
  localparam gsc_mode_t GSC_XOR  = 3'd2;
  localparam gsc_mode_t GSC_NAND = 3'd3;
  localparam gsc_mode_t GSC_NOR  = 3'd4;
  localparam gsc_mode_t GSC_XNOR = 3'd5;

  typedef enum logic [1:0] {
    GSC_IDLE  = 2'd0,
    GSC_DRIVE = 2'd1,
    GSC_DONE  = 2'd2
  } gsc_state_e;

  localparam int GSC_WIDTH_MIN = 1;
  localparam int GSC_WIDTH_MAX = 8;
  localparam int GSC_DWELL_MIN = 1;

endpackage

// File: rtl/gate_ref.sv
// Golden N-input gate: mode-selected reduction of the input vector.
// Reserved modes produce a constant 0.
module gate_ref
  import gsc_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_vec,
  input  gsc_mode_t        i_mode,
  output logic             o_y
);

  always_comb begin
    o_y = 1'b0;
    case (i_mode)
      GSC_AND:  o_y = &i_vec;
      GSC_OR:   o_y = |i_vec;
      GSC_XOR:  o_y = ^i_vec;
      GSC_NAND: o_y = ~&i_vec;
      GSC_NOR:  o_y = ~|i_vec;
      GSC_XNOR: o_y = ~^i_vec;
      default:  o_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for a WIDTH-input gate, holding each vector DWELL cycles.
// Define GSC_LOOPBACK_EN to replace dut_out with an internal gate_ref (board self-test).
module gate_sweep_checker
  import gsc_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DWELL = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             dut_out,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  if (WIDTH < GSC_WIDTH_MIN || WIDTH > GSC_WIDTH_MAX || DWELL < GSC_DWELL_MIN) begin : g_param_check
    $error("gate_sweep_checker: WIDTH must be 1..8 and DWELL at least 1");
  end

  gsc_state_e       r_state, w_state_nxt;
  gsc_mode_t        r_mode, w_mode_nxt;
  logic [WIDTH-1:0] r_stim, w_stim_nxt;
  logic [DW-1:0]    r_dwell, w_dwell_nxt;
  logic [WIDTH:0]   r_err, w_err_nxt;
  logic [WIDTH-1:0] r_first, w_first_nxt;
  logic             w_exp;
  logic             w_dut;

  gate_ref #(.WIDTH(WIDTH)) u_golden (
    .i_vec  (r_stim),
    .i_mode (r_mode),
    .o_y    (w_exp)
  );

`ifdef GSC_LOOPBACK_EN
  logic w_unused_dut;
  assign w_unused_dut = dut_out;

  gate_ref #(.WIDTH(WIDTH)) u_loop (
    .i_vec  (r_stim),
    .i_mode (r_mode),
    .o_y    (w_dut)
  );
`else
  assign w_dut = dut_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GSC_IDLE;
      r_mode  <= GSC_AND;
      r_stim  <= '0;
      r_dwell <= '0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_stim  <= w_stim_nxt;
      r_dwell <= w_dwell_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_stim_nxt  = r_stim;
    w_dwell_nxt = r_dwell;
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    case (r_state)
      GSC_IDLE, GSC_DONE: begin
        if (start) begin
          w_state_nxt = GSC_DRIVE;
          w_mode_nxt  = mode;
          w_stim_nxt  = '0;
          w_dwell_nxt = '0;
          w_err_nxt   = '0;
          w_first_nxt = '0;
        end
      end
      GSC_DRIVE: begin
        // Sample on the last hold cycle so dut_out has settled for DWELL cycles.
        if (r_dwell == DWELL_LAST) begin
          if (w_dut != w_exp) begin
            w_err_nxt = r_err + (WIDTH+1)'(1);
            if (r_err == '0) w_first_nxt = r_stim;
          end
          if (r_stim == '1) begin
            w_state_nxt = GSC_DONE;
          end else begin
            w_stim_nxt  = r_stim + WIDTH'(1);
            w_dwell_nxt = '0;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end
      default: w_state_nxt = GSC_IDLE;
    endcase
  end

  assign stim       = r_stim;
  assign busy       = (r_state == GSC_DRIVE);
  assign done       = (r_state == GSC_DONE);
  assign pass       = (r_state == GSC_DONE) && (r_err == '0);
  assign err_count  = r_err;
  assign first_fail = r_first;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker with a behavioural, fault-injectable gate DUT.
module tb_gate_sweep_checker;
  import gsc_pkg::*;

`ifdef GSC_LOOPBACK_EN
  localparam int W = 4;
  localparam int D = 1;
`else
  localparam int W = 3;
  localparam int D = 2;
`endif
  localparam int NV    = 1 << W;
  localparam int SWEEP = NV * D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic         dut_out;
  logic [W-1:0] stim;
  logic         busy, done, pass;
  logic [W:0]   err_count;
  logic [W-1:0] first_fail;

  int n_vec = 0;
  int n_err = 0;

  int           fault = 0;
  logic [2:0]   dut_mode = 3'd0;
  logic [W-1:0] q_stim[$];
  logic [W-1:0] obs_stim[$];
  int           exp_err;
  logic [W-1:0] exp_first;
  int           cycles;

  gate_sweep_checker #(.WIDTH(W), .DWELL(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .dut_out    (dut_out),
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  function automatic logic ref_gate(input logic [2:0] m, input logic [W-1:0] v);
    logic a, o, x;
    a = 1'b1; o = 1'b0; x = 1'b0;
    for (int i = 0; i < W; i++) begin
      a = a & v[i];
      o = o | v[i];
      x = x ^ v[i];
    end
    case (m)
      3'd0: return a;
      3'd1: return o;
      3'd2: return x;
      3'd3: return ~a;
      3'd4: return ~o;
      3'd5: return ~x;
      default: return 1'b0;
    endcase
  endfunction

  // fault: 0 correct gate, 1 stuck-at-0, 2 plain OR gate, 3 inverted gate
  function automatic logic dut_model(input int f, input logic [2:0] m, input logic [W-1:0] v);
    case (f)
      1: return 1'b0;
      2: return |v;
      3: return ~ref_gate(m, v);
      default: return ref_gate(m, v);
    endcase
  endfunction

  always_comb dut_out = dut_model(fault, dut_mode, stim);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [2:0] m, input int f);
    logic seen;
    q_stim.delete();
    exp_err   = 0;
    exp_first = '0;
    for (int v = 0; v < NV; v++) begin
      for (int d = 0; d < D; d++) q_stim.push_back(W'(v));
`ifdef GSC_LOOPBACK_EN
      seen = ref_gate(m, W'(v));
`else
      seen = dut_model(f, m, W'(v));
`endif
      if (seen !== ref_gate(m, W'(v))) begin
        if (exp_err == 0) exp_first = W'(v);
        exp_err++;
      end
    end
  endtask

  task automatic launch(input logic [2:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic collect(input int pulse_at, input logic [2:0] pmode);
    logic [2:0] keep;
    obs_stim.delete();
    cycles = 0;
    keep   = mode;
    while (busy === 1'b1 && cycles < SWEEP + 20) begin
      obs_stim.push_back(stim);
      if (cycles == pulse_at) begin
        mode  = pmode;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      mode  = keep;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    mode  = GSC_XOR;
    tick();
    tick();
    start = 1'b0;
    rst   = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got %b want 0", pass); end
    n_vec++; if (stim !== '0) begin n_err++; $display("FAIL reset_stim got %0d want 0", stim); end
    n_vec++; if (err_count !== '0) begin n_err++; $display("FAIL reset_err got %0d want 0", err_count); end
    n_vec++; if (first_fail !== '0) begin n_err++; $display("FAIL reset_first got %0d want 0", first_fail); end
  endtask

  task automatic test_sweep(input string name, input logic [2:0] m, input int f,
                            input int pulse_at, input logic [2:0] pmode);
    logic [W-1:0] es;
    fault    = f;
    dut_mode = m;
    push_expected(m, f);
    launch(m);
    n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL %s start busy=%b done=%b want busy=1 done=0", name, busy, done);
    end
    collect(pulse_at, pmode);
    n_vec++; if (cycles != SWEEP) begin
      n_err++; $display("FAIL %s busy_cycles got %0d want %0d", name, cycles, SWEEP);
    end
    for (int i = 0; i < obs_stim.size() && q_stim.size() > 0; i++) begin
      es = q_stim.pop_front();
      n_vec++; if (obs_stim[i] !== es) begin
        n_err++; $display("FAIL %s stim[%0d] got %0d want %0d", name, i, obs_stim[i], es);
      end
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL %s done got %b want 1", name, done); end
    n_vec++; if (err_count !== (W+1)'(exp_err)) begin
      n_err++; $display("FAIL %s err_count got %0d want %0d", name, err_count, exp_err);
    end
    if (exp_err != 0) begin
      n_vec++; if (first_fail !== exp_first) begin
        n_err++; $display("FAIL %s first_fail got %0d want %0d", name, first_fail, exp_first);
      end
    end
    n_vec++; if (pass !== (exp_err == 0)) begin
      n_err++; $display("FAIL %s pass got %b want %b", name, pass, exp_err == 0);
    end
    tick();
    n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s done_hold done=%b busy=%b want done=1 busy=0", name, done, busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    fault    = 3;
    dut_mode = GSC_AND;
    launch(GSC_AND);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      n_err++; $display("FAIL midrst_flags busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
    end
    n_vec++; if (stim !== '0) begin n_err++; $display("FAIL midrst_stim got %0d want 0", stim); end
    n_vec++; if (err_count !== '0) begin n_err++; $display("FAIL midrst_err got %0d want 0", err_count); end
    test_sweep("after_rst", GSC_AND, 0, -1, 3'd0);
  endtask

  task automatic test_restart();
    test_sweep("or_midstart", GSC_OR, 0, SWEEP / 2, GSC_NOR);
    test_sweep("nor_restart", GSC_NOR, 0, -1, 3'd0);
  endtask

  task automatic test_all_modes();
    for (int m = 0; m < 8; m++) test_sweep("mode_ok", 3'(m), 0, -1, 3'd0);
  endtask

`ifdef GSC_LOOPBACK_EN
  task automatic test_loopback();
    for (int m = 0; m < 6; m++) test_sweep("loopback", 3'(m), 1, -1, 3'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_sweep("and_ok", GSC_AND, 0, -1, 3'd0);
    test_sweep("and_stuck0", GSC_AND, 1, -1, 3'd0);
    test_sweep("xor_vs_or", GSC_XOR, 2, -1, 3'd0);
    test_restart();
    test_reset_mid_sweep();
    test_sweep("nand_inverted", GSC_NAND, 3, -1, 3'd0);
    test_all_modes();
`ifdef GSC_LOOPBACK_EN
    test_loopback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
